// File: rtl/game_obj_pkg.sv
// Shared constants and arithmetic for the game-object blocks:
// Galois LFSR tap masks, the default seed and the height scaler.
package game_obj_pkg;

  // Right-shifting Galois tap masks: bit (t-1) set for each polynomial tap t
  localparam logic [31:0] LFSR_TAPS_16 = 32'h0000_B400;
  localparam logic [31:0] LFSR_TAPS_24 = 32'h00E1_0000;
  localparam logic [31:0] LFSR_TAPS_30 = 32'h2000_0029;
  localparam logic [31:0] LFSR_TAPS_32 = 32'h8020_0003;

  localparam logic [29:0] DEFAULT_SEED = 30'h2A5F_1C3D;

  // Tap mask for a given width; unknown widths fall back to a simple top+bottom mask
  function automatic logic [31:0] lfsr_taps(input int width);
    logic [31:0] mask;
    case (width)
      16:      mask = LFSR_TAPS_16;
      24:      mask = LFSR_TAPS_24;
      30:      mask = LFSR_TAPS_30;
      32:      mask = LFSR_TAPS_32;
      default: mask = (32'h1 << (width - 1)) | 32'h1;
    endcase
    return mask;
  endfunction

  // y_min + ((r * range) >> 16): maps a 16-bit random value onto [y_min, y_min+range-1]
  function automatic int unsigned scale_height(input logic [15:0] r,
                                               input int unsigned y_min,
                                               input int unsigned range);
    logic [47:0] prod;
    prod = {32'b0, r} * {16'b0, range};
    return y_min + prod[47:16];
  endfunction

endpackage

// File: rtl/lfsr_galois.sv
// Free-running Galois LFSR with synchronous reload. A zero reload value
// would lock the register up, so it is replaced by SEED.
module lfsr_galois #(
  parameter int             W    = 30,
  parameter logic [W-1:0]   TAPS = W'(30'h2000_0029),
  parameter logic [W-1:0]   SEED = W'(30'h2A5F_1C3D)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] state
);

  logic [W-1:0] r_state;
  logic [W-1:0] w_next;

  // One Galois step: shift right, fold the tap mask in when a one falls out
  always_comb begin
    w_next = {1'b0, r_state[W-1:1]} ^ (r_state[0] ? TAPS : '0);
  end

  // State register: reset to SEED, reload on request, otherwise advance
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= SEED;
    end else if (load) begin
      r_state <= (load_val == '0) ? SEED : load_val;
    end else begin
      r_state <= w_next;
    end
  end

  assign state = r_state;

endmodule

// File: rtl/obstacle_height_gen.sv
// Multi-channel obstacle height generator. Each channel raises a request
// when its obstacle fully leaves the left edge; a round-robin arbiter grants
// one channel per cycle, which takes a height scaled from the shared LFSR.
// Optional feature macro: OBSTACLE_HEIGHT_DELTA_LIMIT_EN limits the step
// between consecutive generated heights to MAX_DELTA.
module obstacle_height_gen
  import game_obj_pkg::*;
#(
  parameter int                N_CH      = 4,
  parameter int                X_W       = 10,
  parameter int                Y_W       = 9,
  parameter int                LFSR_W    = 30,
  parameter int                Y_MIN     = 40,
  parameter int                Y_MAX     = 400,
  parameter logic [LFSR_W-1:0] SEED      = LFSR_W'(DEFAULT_SEED),
  parameter int                MAX_DELTA = 120
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  seed_load,
  input  logic [LFSR_W-1:0]     seed_val,
  input  logic [N_CH*X_W-1:0]   x,
  input  logic [N_CH*X_W-1:0]   w,
  output logic [N_CH*Y_W-1:0]   y,
  output logic [N_CH-1:0]       y_valid,
  output logic                  busy
);

  localparam int unsigned     R     = Y_MAX - Y_MIN + 1;
  localparam logic [Y_W-1:0]  Y_MID = Y_W'(Y_MIN + (Y_MAX - Y_MIN + 1) / 2);
  localparam int              PTR_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(lfsr_taps(LFSR_W));

  logic [LFSR_W-1:0] w_lfsr;
  logic [N_CH-1:0]   w_off;
  logic [N_CH-1:0]   w_req;
  logic [N_CH-1:0]   w_grant;
  logic [N_CH-1:0]   w_pend_next;
  logic [N_CH-1:0]   w_unused_w_lsb;
  logic              w_found;
  logic [PTR_W-1:0]  w_grant_idx;
  logic [PTR_W-1:0]  w_ptr_next;
  logic [Y_W-1:0]    w_y_raw;
  logic [Y_W-1:0]    w_y_new;

  logic [N_CH-1:0]   r_off_q;
  logic [N_CH-1:0]   r_pend;
  logic [N_CH-1:0]   r_y_valid;
  logic              r_busy;
  logic [PTR_W-1:0]  r_ptr;
  logic [Y_W-1:0]    r_y [N_CH];

  lfsr_galois #(
    .W    (LFSR_W),
    .TAPS (TAPS),
    .SEED (SEED)
  ) u_lfsr (
    .clk      (clk),
    .reset    (reset),
    .load     (seed_load),
    .load_val (seed_val),
    .state    (w_lfsr)
  );

  // Only the low 16 LFSR bits feed the scaler
  generate
    if (LFSR_W > 16) begin : g_lfsr_hi
      logic w_unused_lfsr_hi;
      assign w_unused_lfsr_hi = ^w_lfsr[LFSR_W-1:16];
    end
  endgenerate

  // Per-channel offscreen compare: x sign-extended plus w/2 zero-extended, <= 0
  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_off
      logic signed [X_W+1:0] w_sum;
      assign w_sum = {{2{x[gi*X_W+X_W-1]}}, x[gi*X_W +: X_W]}
                   + {3'b000, w[gi*X_W+1 +: X_W-1]};
      assign w_off[gi]          = w_sum[X_W+1] | (w_sum == '0);
      assign w_unused_w_lsb[gi] = w[gi*X_W];
    end
  endgenerate

  // Rising edge of offscreen is the only request source
  assign w_req       = w_off & ~r_off_q;
  assign w_pend_next = (r_pend & ~w_grant) | w_req;

  // Round-robin search starting at the pointer; first pending channel wins
  always_comb begin
    int idx;
    w_grant     = '0;
    w_grant_idx = '0;
    w_found     = 1'b0;
    idx         = 0;
    for (int i = 0; i < N_CH; i++) begin
      idx = int'(r_ptr) + i;
      if (idx >= N_CH) idx = idx - N_CH;
      if (!w_found && r_pend[idx]) begin
        w_found      = 1'b1;
        w_grant[idx] = 1'b1;
        w_grant_idx  = PTR_W'(idx);
      end
    end
  end

  // Pointer moves to the channel after the one just granted
  always_comb begin
    w_ptr_next = (w_grant_idx == PTR_W'(N_CH - 1)) ? '0 : w_grant_idx + 1'b1;
  end

  // Scale the current (pre-advance) LFSR state into [Y_MIN, Y_MAX]
  always_comb begin
    w_y_raw = Y_W'(scale_height(w_lfsr[15:0], Y_MIN, R));
  end

`ifdef OBSTACLE_HEIGHT_DELTA_LIMIT_EN
  logic [Y_W-1:0] r_last_y;

  // Clamp the new height to within MAX_DELTA of the previous one, inside the legal range
  always_comb begin
    int v;
    int lo;
    int hi;
    v  = int'(w_y_raw);
    lo = int'(r_last_y) - MAX_DELTA;
    hi = int'(r_last_y) + MAX_DELTA;
    if (lo < Y_MIN) lo = Y_MIN;
    if (hi > Y_MAX) hi = Y_MAX;
    if (v < lo)      v = lo;
    else if (v > hi) v = hi;
    w_y_new = Y_W'(v);
  end

  // Remember the most recently issued height across all channels
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last_y <= Y_MID;
    end else if (w_found) begin
      r_last_y <= w_y_new;
    end
  end
`else
  localparam int unused_max_delta = MAX_DELTA;
  assign w_y_new = w_y_raw;
`endif

  // Edge-detect history, pending vector, busy flag, pointer and valid pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_off_q   <= '0;
      r_pend    <= '0;
      r_busy    <= 1'b0;
      r_ptr     <= '0;
      r_y_valid <= '0;
    end else begin
      r_off_q   <= w_off;
      r_pend    <= w_pend_next;
      r_busy    <= |w_pend_next;
      r_y_valid <= w_grant;
      if (w_found) r_ptr <= w_ptr_next;
    end
  end

  // Per-channel height register, written only when that channel is granted
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_y
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_y[gi] <= Y_MID;
        end else if (w_grant[gi]) begin
          r_y[gi] <= w_y_new;
        end
      end
      assign y[gi*Y_W +: Y_W] = r_y[gi];
    end
  endgenerate

  assign y_valid = r_y_valid;
  assign busy    = r_busy;

endmodule

// File: tb/tb_obstacle_height_gen.sv
// Scoreboard bench for obstacle_height_gen: expected heights are queued when
// an offscreen edge is driven and checked when the y_valid pulse appears.
module tb_obstacle_height_gen;

  localparam int          N_CH   = 4;
  localparam int          X_W    = 10;
  localparam int          Y_W    = 9;
  localparam int          LFSR_W = 30;
  localparam logic [29:0] SEED_C = 30'h2A5F_1C3D;
  localparam logic [29:0] TAPS_C = 30'h2000_0029;
  localparam int          Y_MID  = 220;
`ifdef OBSTACLE_HEIGHT_DELTA_LIMIT_EN
  localparam int          EXP_DELTA = 340;
`else
  localparam int          EXP_DELTA = 400;
`endif

  logic                clk;
  logic                reset;
  logic                seed_load;
  logic [LFSR_W-1:0]   seed_val;
  logic [N_CH*X_W-1:0] x;
  logic [N_CH*X_W-1:0] w;
  logic [N_CH*Y_W-1:0] y;
  logic [N_CH-1:0]     y_valid;
  logic                busy;

  typedef struct {
    int         ch;
    logic [8:0] yv;
    int         cyc;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  logic [29:0] m_lfsr;
  int          m_ptr    = 0;
  int          m_last_y = Y_MID;

  obstacle_height_gen dut (
    .clk       (clk),
    .reset     (reset),
    .seed_load (seed_load),
    .seed_val  (seed_val),
    .x         (x),
    .w         (w),
    .y         (y),
    .y_valid   (y_valid),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [29:0] lfsr_step(input logic [29:0] s);
    return {1'b0, s[29:1]} ^ (s[0] ? TAPS_C : 30'h0);
  endfunction

  function automatic logic [29:0] lfsr_adv(input logic [29:0] s, input int n);
    logic [29:0] t;
    t = s;
    for (int i = 0; i < n; i++) t = lfsr_step(t);
    return t;
  endfunction

  function automatic int scale_ref(input logic [29:0] s);
    int unsigned p;
    p = 32'(s[15:0]) * 32'd361;
    return 40 + int'(p >> 16);
  endfunction

  // Reference LFSR, independent of the DUT
  always @(posedge clk or negedge reset) begin
    if (!reset)         m_lfsr <= SEED_C;
    else if (seed_load) m_lfsr <= (seed_val == 30'h0) ? SEED_C : seed_val;
    else                m_lfsr <= lfsr_step(m_lfsr);
  end

  task automatic push_exp(input int ch, input logic [29:0] s, input int at_cyc);
    exp_t e;
    int   v;
    v = scale_ref(s);
`ifdef OBSTACLE_HEIGHT_DELTA_LIMIT_EN
    begin
      int lo;
      int hi;
      lo = (m_last_y - 120 < 40) ? 40 : m_last_y - 120;
      hi = (m_last_y + 120 > 400) ? 400 : m_last_y + 120;
      if (v < lo) v = lo;
      else if (v > hi) v = hi;
      m_last_y = v;
    end
`endif
    e.ch  = ch;
    e.yv  = 9'(v);
    e.cyc = at_cyc;
    sb_q.push_back(e);
  endtask

  task automatic set_x(input int ch, input int val);
    x[ch*X_W +: X_W] = X_W'(val);
  endtask

  // Output monitor: every y_valid pulse must match the head of the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b1) begin
      for (int ch = 0; ch < N_CH; ch++) begin
        if (y_valid[ch]) begin
          checks++;
          if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pulse ch=%0d y=%0d cyc=%0d, required no pulse", ch, y[ch*Y_W +: Y_W], cyc);
          end else begin
            e = sb_q.pop_front();
            if (e.ch !== ch || y[ch*Y_W +: Y_W] !== e.yv || cyc !== e.cyc) begin
              errors++;
              $display("FAIL pulse ch=%0d y=%0d cyc=%0d, required ch=%0d y=%0d cyc=%0d",
                       ch, y[ch*Y_W +: Y_W], cyc, e.ch, e.yv, e.cyc);
            end else begin
              $display("pulse ch=%0d y=%0d cyc=%0d ok", ch, y[ch*Y_W +: Y_W], cyc);
            end
          end
        end
      end
    end
  end

  task automatic test_reset();
    reset     = 1'b0;
    seed_load = 1'b0;
    seed_val  = '0;
    for (int ch = 0; ch < N_CH; ch++) begin
      set_x(ch, 200);
      w[ch*X_W +: X_W] = X_W'(40);
    end
    repeat (3) @(negedge clk);
    for (int ch = 0; ch < N_CH; ch++) begin
      checks++;
      if (y[ch*Y_W +: Y_W] !== 9'd220) begin
        errors++;
        $display("FAIL reset_y ch=%0d got %0d want 220", ch, y[ch*Y_W +: Y_W]);
      end
    end
    checks++;
    if (y_valid !== 4'b0) begin errors++; $display("FAIL reset_valid got %b want 0", y_valid); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    reset = 1'b1;
    #1;
    checks++;
    if (dut.u_lfsr.state !== SEED_C) begin
      errors++;
      $display("FAIL reset_lfsr got %h want %h", dut.u_lfsr.state, SEED_C);
    end
    $display("test_reset done");
  endtask

  task automatic test_contention();
    int c;
    @(negedge clk);
    for (int ch = 0; ch < N_CH; ch++) set_x(ch, -100);
    c = cyc;
    for (int k = 0; k < N_CH; k++)
      push_exp((m_ptr + k) % N_CH, lfsr_adv(m_lfsr, 1 + k), c + 2 + k);
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL contention_busy_hi got %b want 1", busy); end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL contention_busy_lo got %b want 0", busy); end
    repeat (2) @(negedge clk);
    checks++;
    if (sb_q.size() !== 0) begin errors++; $display("FAIL contention_drain left %0d want 0", sb_q.size()); end
    for (int ch = 0; ch < N_CH; ch++) set_x(ch, 200);
    $display("test_contention done");
  endtask

  task automatic test_single_wrap();
    int c;
    @(negedge clk); set_x(1, 1); w[1*X_W +: X_W] = X_W'(50);
    @(negedge clk); set_x(1, 0);
    @(negedge clk); set_x(1, -25);
    c = cyc;
    push_exp(1, lfsr_step(m_lfsr), c + 2);
    m_ptr = 2;
    @(negedge clk); set_x(1, -30);
    repeat (8) @(negedge clk);
    checks++;
    if (sb_q.size() !== 0) begin errors++; $display("FAIL single_wrap_drain left %0d want 0", sb_q.size()); end
    checks++;
    if (y[1*Y_W +: Y_W] < 9'd40 || y[1*Y_W +: Y_W] > 9'd400) begin
      errors++;
      $display("FAIL single_wrap_range got %0d want 40..400", y[1*Y_W +: Y_W]);
    end
    set_x(1, 200);
    w[1*X_W +: X_W] = X_W'(40);
    $display("test_single_wrap done");
  endtask

  task automatic test_seed();
    int c;
    // zero seed falls back to SEED
    @(negedge clk); seed_load = 1'b1; seed_val = '0;
    @(negedge clk); seed_load = 1'b0;
    checks++;
    if (dut.u_lfsr.state !== SEED_C) begin
      errors++; $display("FAIL seed_zero got %h want %h", dut.u_lfsr.state, SEED_C);
    end
    // seed of 1 and the sequence that follows
    @(negedge clk); seed_load = 1'b1; seed_val = 30'h1;
    @(negedge clk); seed_load = 1'b0;
    checks++;
    if (dut.u_lfsr.state !== 30'h1) begin
      errors++; $display("FAIL seed_one got %h want 1", dut.u_lfsr.state);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (dut.u_lfsr.state !== lfsr_adv(30'h1, 3)) begin
      errors++; $display("FAIL seed_seq got %h want %h", dut.u_lfsr.state, lfsr_adv(30'h1, 3));
    end
    set_x(2, -100);
    c = cyc;
    push_exp(2, lfsr_step(m_lfsr), c + 2);
    m_ptr = 3;
    repeat (4) @(negedge clk);
    set_x(2, 200);
    // load in the same cycle as a grant: grant keeps the old state
    @(negedge clk); set_x(3, -100);
    c = cyc;
    push_exp(3, lfsr_step(m_lfsr), c + 2);
    m_ptr = 0;
    @(negedge clk); seed_load = 1'b1; seed_val = 30'h1234567;
    @(negedge clk); seed_load = 1'b0;
    checks++;
    if (dut.u_lfsr.state !== 30'h1234567) begin
      errors++; $display("FAIL seed_grant_load got %h want 1234567", dut.u_lfsr.state);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (sb_q.size() !== 0) begin errors++; $display("FAIL seed_drain left %0d want 0", sb_q.size()); end
    set_x(3, 200);
    $display("test_seed done");
  endtask

  task automatic test_delta();
    exp_t e;
    int   c;
    @(negedge clk);
    reset = 1'b0;
    sb_q.delete();
    m_ptr    = 0;
    m_last_y = Y_MID;
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    set_x(0, -100);
    seed_load = 1'b1;
    seed_val  = 30'h0001_FFFF;
    c = cyc;
    e.ch = 0; e.yv = 9'(EXP_DELTA); e.cyc = c + 2;
    sb_q.push_back(e);
    m_last_y = EXP_DELTA;
    m_ptr    = 1;
    @(negedge clk); seed_load = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (sb_q.size() !== 0) begin errors++; $display("FAIL delta_drain left %0d want 0", sb_q.size()); end
    set_x(0, 200);
    $display("test_delta done");
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    for (int ch = 0; ch < 3; ch++) set_x(ch, -100);
    @(posedge clk);
    #2;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL async_pre_busy got %b want 1", busy); end
    reset = 1'b0;
    sb_q.delete();
    m_ptr    = 0;
    m_last_y = Y_MID;
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL async_busy got %b want 0", busy); end
    checks++;
    if (dut.r_pend !== 4'b0) begin errors++; $display("FAIL async_pend got %b want 0", dut.r_pend); end
    checks++;
    if (y_valid !== 4'b0) begin errors++; $display("FAIL async_valid got %b want 0", y_valid); end
    @(negedge clk);
    for (int ch = 0; ch < N_CH; ch++) set_x(ch, 200);
    @(negedge clk); reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (y_valid !== 4'b0) begin errors++; $display("FAIL async_quiet got %b want 0", y_valid); end
    end
    $display("test_async_reset done");
  endtask

  initial begin
    reset = 1'b0;
    x = '0;
    w = '0;
    seed_load = 1'b0;
    seed_val = '0;
    test_reset();
    test_contention();
    test_single_wrap();
    test_seed();
    test_delta();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
